// File: rtl/program_loader.sv
// program_loader: writes a framed byte stream into instruction memory.
// Frame: length L (16-bit LE word count), L little-endian 16-bit words, XOR checksum byte.
// Holds the CPU in reset while a load is in progress.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load_start          one-cycle load request (honoured in IDLE/ERROR)
//   load_abort          return to IDLE from any state, flags untouched
//   byte_valid/_data    stream byte in; byte_ready accepts it
//   imem_write_enable   one-cycle write strobe with imem_address/imem_write_data
//   cpu_hold            CPU reset hold while loading
//   load_done           one-cycle success pulse
//   load_error          sticky error flag, cleared by load_start
module program_loader #(
  parameter int unsigned INST_W   = 16,
  parameter int unsigned I_ADDR_W = 12,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                load_abort,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                byte_ready,
  output logic                imem_write_enable,
  output logic [I_ADDR_W-1:0] imem_address,
  output logic [INST_W-1:0]   imem_write_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_error
);

  localparam int unsigned LEN_W = 2 * BYTE_W;
  localparam int unsigned REM_W = I_ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << I_ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t              r_state;
  logic [BYTE_W-1:0]   r_len_lo;
  logic [BYTE_W-1:0]   r_data_lo;
  logic [BYTE_W-1:0]   r_chk;
  logic [REM_W-1:0]    r_remaining;
  logic [I_ADDR_W-1:0] r_addr;
  logic [INST_W-1:0]   r_wdata;
  logic                r_error;

  logic                w_xfer;
  logic [LEN_W-1:0]    w_len;
  logic                w_len_bad;

  // Status outputs are decoded straight from the state register.
  assign byte_ready = (r_state == S_LEN_LO)  || (r_state == S_LEN_HI) ||
                      (r_state == S_DATA_LO) || (r_state == S_DATA_HI) ||
                      (r_state == S_CHECK);
  assign imem_write_enable = (r_state == S_WRITE);
  assign load_done         = (r_state == S_DONE);
  assign cpu_hold          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign load_error        = r_error;
  assign imem_address      = r_addr;
  assign imem_write_data   = r_wdata;

  assign w_xfer    = byte_valid && byte_ready;
  assign w_len     = {byte_data, r_len_lo};
  assign w_len_bad = (w_len == '0) || (32'(w_len) > MAX_LEN);

  // Loader FSM with its counters and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_data_lo   <= '0;
      r_chk       <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_error     <= 1'b0;
    end else if (load_abort) begin
      r_state <= S_IDLE;
      // The write strobe of this cycle still lands, so keep the counters consistent.
      if (r_state == S_WRITE) begin
        r_addr      <= r_addr + I_ADDR_W'(1);
        r_remaining <= r_remaining - REM_W'(1);
      end
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (load_start) begin
            r_state <= S_LEN_LO;
            r_addr  <= '0;
            r_chk   <= '0;
            r_error <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len_lo <= byte_data;
            r_chk    <= r_chk ^ byte_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ byte_data;
            if (w_len_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_remaining <= REM_W'(w_len);
              r_state     <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (w_xfer) begin
            r_data_lo <= byte_data;
            r_chk     <= r_chk ^ byte_data;
            r_state   <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_xfer) begin
            r_wdata <= {byte_data, r_data_lo};
            r_chk   <= r_chk ^ byte_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + I_ADDR_W'(1);
          r_remaining <= r_remaining - REM_W'(1);
          r_state     <= (r_remaining == REM_W'(1)) ? S_CHECK : S_DATA_LO;
        end
        S_CHECK: begin
          if (w_xfer) begin
            if (byte_data == r_chk) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes and
// completion events; a negedge monitor pops and compares them.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_write_enable;
  logic [11:0] imem_address;
  logic [15:0] imem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  program_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_start        (load_start),
    .load_abort        (load_abort),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .imem_write_enable (imem_write_enable),
    .imem_address      (imem_address),
    .imem_write_data   (imem_write_data),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_error        (load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [27:0] exp_wr[$];   // {addr, data}
  logic [7:0]  exp_ev[$];   // "D" done, "E" error
  logic [15:0] words[$];    // preset words for the next frame
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Monitor: compare every write strobe and completion event with the scoreboard.
  always @(negedge clk) begin
    logic [27:0] e;
    logic [7:0]  ev;
    if (rst_n) begin
      if (imem_write_enable) begin
        check("ready_during_write", 32'(byte_ready), 32'd0);
        if (exp_wr.size() == 0) fail_now("unexpected_write", {4'h0, imem_address, imem_write_data});
        else begin
          e = exp_wr.pop_front();
          check("write", {4'h0, imem_address, imem_write_data}, {4'h0, e});
        end
      end
      if (load_done) begin
        check("hold_low_at_done", 32'(cpu_hold), 32'd0);
        if (exp_ev.size() == 0) fail_now("unexpected_done", 32'd1);
        else begin
          ev = exp_ev.pop_front();
          check("outcome_done", 32'("D"), 32'(ev));
        end
      end
      if (load_error && !prev_err) begin
        if (exp_ev.size() == 0) fail_now("unexpected_error", 32'd1);
        else begin
          ev = exp_ev.pop_front();
          check("outcome_error", 32'("E"), 32'(ev));
        end
      end
    end
    prev_err = load_error;
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("byte_accept_timeout", 32'(b));
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("error_cleared", 32'(load_error), 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_ev.size() != 0 || exp_wr.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail_now("drain_timeout", 32'(exp_ev.size() + exp_wr.size()));
  endtask

  // Reference model at frame level: header decides validity, words go to
  // addresses 0..L-1, outcome decided by comparing the sent checksum with XOR.
  task automatic run_frame(input int len, input logic [7:0] chk_flip, input int maxgap);
    logic [7:0]  chk;
    logic [15:0] w;
    logic [15:0] l16;
    l16 = 16'(len);
    start_load();
    chk = l16[7:0] ^ l16[15:8];
    if (len == 0 || len > 4096) begin
      exp_ev.push_back("E");
      send_byte(l16[7:0], maxgap);
      send_byte(l16[15:8], maxgap);
      wait_drain();
      @(negedge clk);
      check("error_sticky", 32'(load_error), 32'd1);
      check("error_hold", 32'(cpu_hold), 32'd1);
      return;
    end
    send_byte(l16[7:0], maxgap);
    send_byte(l16[15:8], maxgap);
    for (int i = 0; i < len; i++) begin
      w = (words.size() != 0) ? words.pop_front() : 16'($urandom);
      exp_wr.push_back({12'(i), w});
      chk = chk ^ w[7:0] ^ w[15:8];
      send_byte(w[7:0], maxgap);
      send_byte(w[15:8], maxgap);
    end
    exp_ev.push_back((chk_flip == 8'h00) ? 8'("D") : 8'("E"));
    send_byte(chk ^ chk_flip, maxgap);
    wait_drain();
    @(negedge clk);
    check("final_error_flag", 32'(load_error), (chk_flip == 8'h00) ? 32'd0 : 32'd1);
    check("final_hold", 32'(cpu_hold), (chk_flip == 8'h00) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #1;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(imem_write_enable), 32'd0);
    check("rst_addr_data", {4'h0, imem_address, imem_write_data}, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_flags", {30'd0, load_done, load_error}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic two-word load.
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    run_frame(2, 8'h00, 0);

    // Bad checksum: both writes still land, error sticks.
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    run_frame(2, 8'h01, 0);

    // Length zero and oversize headers.
    run_frame(0, 8'h00, 0);
    run_frame(32'h1001, 8'h00, 0);

    // One-word load with random gaps.
    for (int k = 0; k < 4; k++) begin
      words.push_back(16'h5678);
      run_frame(1, 8'h00, 3);
    end

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      run_frame(int'($urandom_range(6, 1)),
                ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
                int'($urandom_range(3)));
    end

    // Abort after the first DATA_LO byte: no write, back to IDLE.
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_error", 32'(load_error), 32'd0);
    repeat (3) @(negedge clk);

    // Reset pulsed while in DATA_HI.
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_we", 32'(imem_write_enable), 32'd0);
    check("midrst_addr_data", {4'h0, imem_address, imem_write_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-size load exercises the last address and wrap.
    run_frame(4096, 8'h00, 0);
    run_frame(3, 8'h00, 1);

    check("scoreboard_empty", 32'(exp_wr.size() + exp_ev.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
